fp32_argmax_stream: RTL and testbench
=====================================

# fp32_argmax_stream

Streaming, parametrised top-2 argmax unit for the CNN classifier output stage. Accepts NUM_CLASSES IEEE-754 float32 scores one per cycle over a valid/ready stream. Tracks the best and runner-up scores and their class indices, then presents one result per frame on a valid/ready output. It sits between the final fully-connected layer and the result/display logic, and replaces one-shot combinational winner selection with a pipelined, back-pressurable frame processor.

## Interface
- NUM_CLASSES, 10: scores per frame; must be ≥ 2.
- IDX_W, $clog2(NUM_CLASSES): width of index outputs.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  score present on in_data.
- in_ready  out  1  block can accept a score.
- in_data  in  32  float32 score; element k of a frame is class k.
- in_last  in  1  producer's end-of-frame marker; used for checking only.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_idx  out  IDX_W  class index of maximum.
- out_val  out  32  maximum score.
- out_idx2  out  IDX_W  class index of runner-up.
- out_err  out  1  frame contained a NaN, or in_last was misplaced.

## Operation
- Two states:
  - COLLECT: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Reset state is COLLECT. All registers clear to 0, including cnt, best/second value and index, err, and the second-present flag.
- COLLECT, on in_valid&in_ready (accept), with element index = cnt:
  - First element (cnt=0): best←(data,0), second empty, err←(NaN or in_last).
  - Otherwise:
    - If data > best: second←best, best←(data,cnt).
    - Else if second empty or data > second: second←(data,cnt).
  - cnt increments on every accept.
  - On the accept with cnt=NUM_CLASSES-1: cnt←0, state←EMIT.
- Ordering: strict greater-than on float32 values. −0 equals +0. Subnormals compare by value. ±Inf are ordinary extremes.
- NaN: never greater than anything, and nothing is greater than NaN. A NaN at cnt=0 is replaced by the first non-NaN element. Any NaN sets err.
- Ties: an equal score never replaces the current holder, so the lowest index wins.
- in_last check:
  - in_last=1 on any element other than NUM_CLASSES-1 sets err.
  - in_last=0 on element NUM_CLASSES-1 sets err.
  - The frame boundary is always count-based; in_last never truncates or extends a frame.
- EMIT: the outputs show the registered best, second and err, and stay stable until out_valid&out_ready. On that handshake: state←COLLECT, err cleared, second marked empty.

## Timing
- Throughput: one score per cycle while in COLLECT and in_valid=1.
- Latency: out_valid rises the cycle after the last element is accepted.
- The first element of the next frame is accepted no earlier than the cycle after the output handshake. There is no overlap, which gives 1 bubble cycle per frame minimum.
- out_* and in_ready are registered or state-decoded; there is no combinational path from in_* to out_*.
- rst asserted mid-frame or in EMIT: outputs are immediately out_valid=0 and out_idx/out_idx2/out_val/out_err=0. in_ready=0 while rst is high, and 1 in the first cycle after release. Any partial frame is discarded.
- in_valid with in_ready=0 (EMIT): no accept. The producer must hold its data.

## Structure
- Shared package cnn_pkg: FP32_W=32, the canonical quiet-NaN constant 32'h7FC00000, and a state enum {COLLECT, EMIT}.
- Sub-module fp32_gt: combinational a>b for float32 with the NaN and ±0 rules above. It is instantiated twice (data vs best, data vs second).
- Everything else lives in one module: counter, state register, best/second registers.

## Test plan
- NUM_CLASSES=10, scores class k = k·1.0 except class 7 = 3F800000·(large, 42400000=48.0) -> out_idx=7, out_val=42400000, out_idx2=9, out_err=0.
- Ties: class 2 and class 5 both 40400000 (3.0), all others BF800000 (−1.0) -> out_idx=2, out_idx2=5.
- NaN: class 0 = 7FC00000, class 4 = 40000000, all others 00000000 -> out_idx=4, out_err=1. Also, 80000000 vs 00000000 produces no replacement.
- Back-pressure: hold out_ready=0 for 20 cycles -> outputs stable and in_ready=0 throughout. Then pulse out_ready -> next frame accepted back-to-back with correct result.
- in_last asserted on element 6 of 10 -> frame still ends after element 9, out_err=1. The following clean frame gives out_err=0.
- Assert rst after 5 accepted elements -> out_valid=0 and in_ready=0 during reset. A fresh 10-element frame after release gives a result unaffected by the discarded elements.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN classifier output stage.
package cnn_pkg;

    localparam int unsigned FP32_W = 32;
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    function automatic logic fp32_is_nan(input logic [FP32_W-1:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    function automatic logic fp32_is_zero(input logic [FP32_W-1:0] x);
        return ~|x[30:0];
    endfunction

    // Maps float32 bit patterns onto unsigned keys whose order matches numeric order.
    function automatic logic [FP32_W-1:0] fp32_key(input logic [FP32_W-1:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational float32 a > b; NaN compares false both ways, -0 equals +0.
module fp32_gt
    import cnn_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic              gt_c
);

    logic any_nan;
    logic both_zero;

    always_comb begin
        any_nan   = fp32_is_nan(a) || fp32_is_nan(b);
        both_zero = fp32_is_zero(a) && fp32_is_zero(b);
        gt_c      = !any_nan && !both_zero && (fp32_key(a) > fp32_key(b));
    end

endmodule

// File: rtl/fp32_argmax_stream.sv
// Streaming top-2 argmax over NUM_CLASSES float32 scores per frame.
module fp32_argmax_stream
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [FP32_W-1:0] out_val,
    output logic [IDX_W-1:0]  out_idx2,
    output logic              out_err
);

    state_t              state, state_n;
    logic [IDX_W-1:0]    cnt, cnt_n;
    logic [FP32_W-1:0]   best_val, best_val_n;
    logic [IDX_W-1:0]    best_idx, best_idx_n;
    logic [FP32_W-1:0]   sec_val, sec_val_n;
    logic [IDX_W-1:0]    sec_idx, sec_idx_n;
    logic                sec_vld, sec_vld_n;
    logic                err, err_n;

    logic gt_best_c, gt_sec_c;
    logic accept, first_elem, last_elem, data_nan, best_nan;

    fp32_gt u_gt_best (.a(in_data), .b(best_val), .gt_c(gt_best_c));
    fp32_gt u_gt_sec  (.a(in_data), .b(sec_val),  .gt_c(gt_sec_c));

    always_comb begin
        first_elem = (cnt == '0);
        last_elem  = (cnt == IDX_W'(NUM_CLASSES - 1));
        data_nan   = fp32_is_nan(in_data);
        best_nan   = fp32_is_nan(best_val);
    end

    // Next-state, datapath update and handshake decode.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        best_val_n = best_val;
        best_idx_n = best_idx;
        sec_val_n  = sec_val;
        sec_idx_n  = sec_idx;
        sec_vld_n  = sec_vld;
        err_n      = err;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;

        unique case (state)
            COLLECT: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) begin
                    cnt_n = last_elem ? '0 : cnt + IDX_W'(1);
                    if (last_elem) state_n = EMIT;
                    err_n = (first_elem ? 1'b0 : err) | data_nan | (in_last != last_elem);
                    if (first_elem) begin
                        best_val_n = in_data;
                        best_idx_n = '0;
                        sec_vld_n  = 1'b0;
                    end else if (!data_nan) begin
                        // A NaN held as best (from element 0) yields to any real score.
                        if (best_nan || gt_best_c) begin
                            if (!best_nan) begin
                                sec_val_n = best_val;
                                sec_idx_n = best_idx;
                                sec_vld_n = 1'b1;
                            end
                            best_val_n = in_data;
                            best_idx_n = cnt;
                        end else if (!sec_vld || gt_sec_c) begin
                            sec_val_n = in_data;
                            sec_idx_n = cnt;
                            sec_vld_n = 1'b1;
                        end
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n   = COLLECT;
                    err_n     = 1'b0;
                    sec_vld_n = 1'b0;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            best_val <= '0;
            best_idx <= '0;
            sec_val  <= '0;
            sec_idx  <= '0;
            sec_vld  <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            best_val <= best_val_n;
            best_idx <= best_idx_n;
            sec_val  <= sec_val_n;
            sec_idx  <= sec_idx_n;
            sec_vld  <= sec_vld_n;
            err      <= err_n;
        end
    end

    assign out_idx  = best_idx;
    assign out_val  = best_val;
    assign out_idx2 = sec_idx;
    assign out_err  = err;

endmodule

// File: tb/tb_fp32_argmax_stream.sv
// Directed self-checking bench for fp32_argmax_stream with NUM_CLASSES=10.
module tb_fp32_argmax_stream;
    import cnn_pkg::*;

    localparam int unsigned N  = 10;
    localparam int unsigned IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [31:0]   out_val;
    logic [IW-1:0] out_idx2;
    logic          out_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] fr [N];
    int lastpos;

    fp32_argmax_stream #(.NUM_CLASSES(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_val(out_val), .out_idx2(out_idx2), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents fr[0..n-1] back-to-back; in_last on element lastpos.
    task automatic send_frame(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = fr[i];
            in_last  = (i == lastpos);
            cyc = 0;
            while (!in_ready && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [IW-1:0] idx,
                                input logic [31:0] val, input logic [IW-1:0] idx2,
                                input logic err);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_idx"},   32'(out_idx), 32'(idx));
        check({tag, "_val"},   out_val, val);
        check({tag, "_idx2"},  32'(out_idx2), 32'(idx2));
        check({tag, "_err"},   32'(out_err), 32'(err));
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_pop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pop_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        lastpos = N - 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_idx",   32'(out_idx), 32'd0);
        check("rst_val",   out_val, 32'd0);
        check("rst_idx2",  32'(out_idx2), 32'd0);
        check("rst_err",   32'(out_err), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // k*1.0 with class 7 = 48.0
        fr = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h4240_0000, 32'h4100_0000, 32'h4110_0000};
        send_frame(N);
        check_result("basic", 4'd7, 32'h4240_0000, 4'd9, 1'b0);
        pop("basic");

        // ties at 2 and 5
        fr = '{32'hBF80_0000, 32'hBF80_0000, 32'h4040_0000, 32'hBF80_0000, 32'hBF80_0000,
               32'h4040_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        send_frame(N);
        check_result("tie", 4'd2, 32'h4040_0000, 4'd5, 1'b0);
        pop("tie");

        // NaN first, 2.0 at class 4, zeros elsewhere
        fr = '{FP32_QNAN, 32'h0, 32'h0, 32'h0, 32'h4000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        send_frame(N);
        check_result("nan", 4'd4, 32'h4000_0000, 4'd1, 1'b1);
        pop("nan");

        // +0 then -0: no replacement
        fr = '{32'h0000_0000, 32'h8000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000,
               32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        send_frame(N);
        check_result("pzero", 4'd0, 32'h0000_0000, 4'd1, 1'b0);
        pop("pzero");

        // -0 then +0: no replacement
        fr[0] = 32'h8000_0000;
        fr[1] = 32'h0000_0000;
        send_frame(N);
        check_result("nzero", 4'd0, 32'h8000_0000, 4'd1, 1'b0);
        pop("nzero");

        // back-pressure: hold result for 20 cycles with input pending
        fr = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h4240_0000, 32'h4100_0000, 32'h4110_0000};
        send_frame(N);
        check_result("bp_first", 4'd7, 32'h4240_0000, 4'd9, 1'b0);
        fr = '{32'hBF80_0000, 32'hBF80_0000, 32'h4040_0000, 32'hBF80_0000, 32'hBF80_0000,
               32'h4040_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        in_valid = 1'b1;
        in_data  = fr[0];
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_idx",   32'(out_idx), 32'd7);
            check("bp_val",   out_val, 32'h4240_0000);
            check("bp_idx2",  32'(out_idx2), 32'd9);
        end
        pop("bp");
        send_frame(N);
        check_result("bp_next", 4'd2, 32'h4040_0000, 4'd5, 1'b0);
        pop("bp_next");

        // misplaced in_last on element 6
        fr = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h4240_0000, 32'h4100_0000, 32'h4110_0000};
        lastpos = 6;
        send_frame(N);
        check_result("last_bad", 4'd7, 32'h4240_0000, 4'd9, 1'b1);
        pop("last_bad");
        lastpos = N - 1;
        fr = '{32'hBF80_0000, 32'hBF80_0000, 32'h4040_0000, 32'hBF80_0000, 32'hBF80_0000,
               32'h4040_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        send_frame(N);
        check_result("last_clean", 4'd2, 32'h4040_0000, 4'd5, 1'b0);
        pop("last_clean");

        // reset after 5 large elements, then a clean frame
        for (int i = 0; i < int'(N); i++) fr[i] = 32'h42C8_0000;
        send_frame(5);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_val",   out_val, 32'd0);
        check("mid_rst_idx",   32'(out_idx), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_ready2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(in_ready), 32'd1);
        fr = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h4240_0000, 32'h4100_0000, 32'h4110_0000};
        send_frame(N);
        check_result("after_rst", 4'd7, 32'h4240_0000, 4'd9, 1'b0);
        pop("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
